// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, registers the fetched word into IF/ID,
// and redirects on a taken CBZ resolved from the instruction currently held in IF/ID.
module if_stage #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch,
    input  logic                zero,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic                if_id_valid,
    output logic [10:0]         opcode,
    output logic [31:0]         fetch_count
);

    // CBZ byte offset: imm19 sign-extended to the PC width, then scaled by 4.
    function automatic logic signed [PC_WIDTH-1:0] cbz_offset(input logic [31:0] instr);
        logic signed [18:0]         imm19;
        logic signed [PC_WIDTH-1:0] ext;
        imm19 = instr[23:5];
        ext   = PC_WIDTH'(imm19);
        return ext <<< 2;
    endfunction

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] branch_target;
    logic                taken;

    assign imem_addr     = pc;
    assign opcode        = if_id_instr[31:21];
    assign pc_plus4      = pc + PC_WIDTH'(4);
    assign branch_target = if_id_pc + $unsigned(cbz_offset(if_id_instr));
    // A bubble in IF/ID must never redirect, whatever ID decodes from the zero word.
    assign taken         = branch & zero & if_id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else if (taken) begin
            // Redirect outranks stall/flush; the wrong-path word on imem_rdata is dropped.
            pc          <= branch_target;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
            end
        end else begin
            pc <= pc_plus4;
            if (flush) begin
                if_id_instr <= '0;
                if_id_pc    <= '0;
                if_id_valid <= 1'b0;
            end else begin
                if_id_instr <= imem_rdata;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, CBZ taken/not-taken, wrap-around,
// stall/flush interaction and asynchronous reset in the middle of a redirect.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch, zero;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] pc;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic [10:0] opcode;
    logic [31:0] fetch_count;

    int n_assert = 0;
    int n_fail   = 0;
    int mem_sel  = 0;

    if_stage #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch(branch), .zero(zero), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .opcode(opcode),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory images: background word is 0xF8400000+addr; each image plants one CBZ.
    function automatic logic [31:0] mem_word(input int sel, input logic [63:0] a);
        logic [31:0] w;
        w = 32'hF840_0000 + a[31:0];
        if (sel == 0 && a == 64'h10) w = 32'hB400_0040;
        if (sel == 1 && a == 64'h0)  w = 32'hB4FF_FFE0;
        if (sel == 2 && a == 64'h1C) w = 32'hB400_0040;
        return w;
    endfunction

    always_comb imem_rdata = mem_word(mem_sel, imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [63:0] e_pc, input logic [31:0] e_instr,
                             input logic [63:0] e_ipc, input logic e_vld, input logic [31:0] e_cnt);
        chk({tag, ".pc"},    pc,          e_pc);
        chk({tag, ".addr"},  imem_addr,   e_pc);
        chk({tag, ".instr"}, if_id_instr, {32'h0, e_instr});
        chk({tag, ".ifpc"},  if_id_pc,    e_ipc);
        chk({tag, ".valid"}, if_id_valid, {63'h0, e_vld});
        chk({tag, ".count"}, fetch_count, {32'h0, e_cnt});
    endtask

    task automatic do_reset(input int sel);
        reset   = 1'b1;
        mem_sel = sel;
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch = 1'b0; zero = 1'b0;
        #3;
        chk_state("rst_async", 64'h0, 32'h0, 64'h0, 1'b0, 32'd0);
        chk("rst_opcode", opcode, 64'h0);
        tick();
        chk_state("rst_hold", 64'h0, 32'h0, 64'h0, 1'b0, 32'd0);

        // Sequential fetch from address 0
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_state($sformatf("seq%0d", k), 64'(4 * k), 32'hF840_0000 + 32'(4 * (k - 1)),
                      64'(4 * (k - 1)), 1'b1, 32'(k));
        end
        chk("seq_opcode", opcode, 64'h7C2);

        // CBZ at 0x10, taken: target 0x18, one bubble
        tick();
        chk_state("cbz_load", 64'h14, 32'hB400_0040, 64'h10, 1'b1, 32'd5);
        chk("cbz_opcode", opcode, 64'h5A0);
        branch = 1'b1; zero = 1'b1;
        tick();
        chk_state("cbz_taken", 64'h18, 32'h0, 64'h0, 1'b0, 32'd5);
        tick();  // bubble in IF/ID: branch still high but must not redirect
        chk_state("cbz_after", 64'h1C, 32'hF840_0018, 64'h18, 1'b1, 32'd6);
        branch = 1'b0; zero = 1'b0;

        // Same CBZ, not taken
        do_reset(0);
        repeat (5) tick();
        chk_state("nt_load", 64'h14, 32'hB400_0040, 64'h10, 1'b1, 32'd5);
        branch = 1'b1; zero = 1'b0;
        tick();
        chk_state("nt_edge", 64'h18, 32'hF840_0014, 64'h14, 1'b1, 32'd6);
        branch = 1'b0;

        // Backward CBZ, imm19 = -1, from if_id_pc 0
        do_reset(1);
        tick();
        chk_state("bk_load", 64'h4, 32'hB4FF_FFE0, 64'h0, 1'b1, 32'd1);
        branch = 1'b1; zero = 1'b1;
        tick();
        chk_state("bk_taken", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'h0, 1'b0, 32'd1);
        branch = 1'b0; zero = 1'b0;
        tick();
        chk_state("bk_wrap", 64'h0, 32'hF83F_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'd2);

        // Stall at pc 0x20 with the CBZ from 0x1C held in IF/ID
        do_reset(2);
        repeat (8) tick();
        chk_state("st_pre", 64'h20, 32'hB400_0040, 64'h1C, 1'b1, 32'd8);
        stall = 1'b1;
        repeat (3) tick();
        chk_state("st_hold", 64'h20, 32'hB400_0040, 64'h1C, 1'b1, 32'd8);
        branch = 1'b1; zero = 1'b1;
        tick();
        chk_state("st_redir", 64'h24, 32'h0, 64'h0, 1'b0, 32'd8);
        stall = 1'b0; branch = 1'b0; zero = 1'b0;
        tick();
        chk_state("st_fetch", 64'h28, 32'hF840_0024, 64'h24, 1'b1, 32'd9);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_state("st_flush", 64'h28, 32'h0, 64'h24, 1'b0, 32'd9);
        stall = 1'b0;
        tick();
        chk_state("nrm_flush", 64'h2C, 32'h0, 64'h0, 1'b0, 32'd9);
        flush = 1'b0;

        // Asynchronous reset between edges while a taken CBZ is pending
        do_reset(0);
        repeat (5) tick();
        branch = 1'b1; zero = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_state("ar_immed", 64'h0, 32'h0, 64'h0, 1'b0, 32'd0);
        tick();
        chk_state("ar_hold", 64'h0, 32'h0, 64'h0, 1'b0, 32'd0);
        reset = 1'b0; branch = 1'b0; zero = 1'b0;
        tick();
        chk_state("ar_resume", 64'h4, 32'hF840_0000, 64'h0, 1'b1, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
